// File: rtl/gru_hidden_streamer.sv
// gru_hidden_streamer: captures the GRU cell's parallel h_t on each done pulse,
// keeps it as the recurrent h_state and streams it as H words over valid/ready.
// Optional macro GRU_STREAM_PARITY_EN adds an m_parity output (XOR of m_data).
module gru_hidden_streamer #(
  parameter int H           = 16,
  parameter int DATA_WIDTH  = 26,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      done_in,
  input  logic [H*DATA_WIDTH-1:0]   h_t_in,
  input  logic                      m_ready,
  output logic                      m_valid,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_last,
  output logic [$clog2(H)-1:0]      m_index,
  output logic [H*DATA_WIDTH-1:0]   h_state,
  output logic                      busy,
  output logic                      overrun,
`ifdef GRU_STREAM_PARITY_EN
  output logic                      m_parity,
`endif
  output logic [FRAME_CNT_W-1:0]    frame_cnt
);

  localparam int IDX_W = $clog2(H);

  typedef enum logic {S_IDLE, S_STREAM} state_t;
  state_t state;

  // h_state doubles as the frame buffer: both change only on accepted captures.
  logic                  hs;
  logic                  last_hs;
  logic                  capture;
  logic                  drop;
  logic [IDX_W-1:0]      next_idx;
  logic [DATA_WIDTH-1:0] word_next;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load;

  // Handshake decode and selection of the word to present next.
  always_comb begin
    hs        = m_valid & m_ready;
    last_hs   = hs & m_last;
    capture   = done_in & ((state == S_IDLE) | last_hs);
    drop      = done_in & (state == S_STREAM) & ~last_hs;
    next_idx  = m_index + IDX_W'(1);
    word_next = h_state[int'(next_idx)*DATA_WIDTH +: DATA_WIDTH];
    load      = 1'b0;
    load_data = m_data;
    if (capture) begin
      load      = 1'b1;
      load_data = h_t_in[DATA_WIDTH-1:0];
    end else if ((state == S_STREAM) && hs && !m_last) begin
      load      = 1'b1;
      load_data = word_next;
    end
  end

  // Control FSM with registered stream outputs; a final handshake coinciding
  // with done_in restarts the next frame without a valid bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      m_index   <= '0;
      h_state   <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
`ifdef GRU_STREAM_PARITY_EN
      m_parity  <= 1'b0;
`endif
    end else begin
      if (capture) begin
        state   <= S_STREAM;
        h_state <= h_t_in;
        m_index <= '0;
        m_valid <= 1'b1;
        busy    <= 1'b1;
        m_last  <= 1'b0;
      end else if ((state == S_STREAM) && hs) begin
        if (m_last) begin
          state   <= S_IDLE;
          m_valid <= 1'b0;
          busy    <= 1'b0;
          m_last  <= 1'b0;
        end else begin
          m_index <= next_idx;
          m_last  <= (next_idx == IDX_W'(H-1));
        end
      end
      if (load) begin
        m_data   <= load_data;
`ifdef GRU_STREAM_PARITY_EN
        m_parity <= ^load_data;
`endif
      end
      if (last_hs) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      if (drop)    overrun   <= 1'b1;
    end
  end

endmodule

// File: doc/gru_hidden_streamer.md
Name: gru_hidden_streamer

Overview:
- Consumer end of the GRU cell's hidden-state output.
- Each `done` pulse from the GRU cell captures the full parallel h_t vector, then serializes it as H words over a valid/ready stream with a last marker.
- Also holds the captured vector as h_state, which the top level feeds back as h_t_prev for the next timestep.
- Sits between the gru_cell_parallel instance and the downstream result sink or DMA.

Parameters:
- H, 16, hidden units per frame (≥2).
- DATA_WIDTH, 26, word width, signed Q10.16 (INT_BITS+FRAC_BITS).
- FRAME_CNT_W, 16, width of frame counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- done_in  in  1  one-cycle pulse from GRU cell; h_t_in valid in that cycle.
- h_t_in  in  H*DATA_WIDTH  packed h_t; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_ready  in  1  downstream ready.
- m_valid  out  1  stream word valid.
- m_data  out  DATA_WIDTH  current element, signed.
- m_last  out  1  high with element H-1.
- m_index  out  $clog2(H)  index of current element.
- h_state  out  H*DATA_WIDTH  last accepted h_t vector (recurrent feedback).
- busy  out  1  high in STREAM state.
- overrun  out  1  sticky; set when a done_in is dropped.
- frame_cnt  out  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0: m_valid, m_data, m_last, m_index, h_state (all-zero), busy, overrun, frame_cnt. Reset mid-frame abandons the frame with no partial-count effect.
- IDLE: done_in=1 → capture h_t_in into the frame buffer and h_state, index=0, go to STREAM. From the next cycle, m_valid=1 with m_data=element 0. Latency is done_in edge N to first valid word at N+1.
- STREAM: m_valid=1, m_data=buffer[index], m_last=(index==H-1), busy=1.
  - Handshake = m_valid & m_ready. On a handshake with index<H-1, index increments.
  - While m_ready=0, m_data, m_index and m_last are held stable.
  - Handshake at index=H-1 increments frame_cnt (with wrap) and returns to IDLE; m_valid=0 on the next cycle.
- Simultaneous done_in with the final handshake (index=H-1): the new vector is accepted. Capture, index←0, stay in STREAM. m_valid stays 1 with no bubble. frame_cnt still increments.
- done_in in STREAM at any other time: the pulse is dropped, overrun←1 (sticky until reset), and buffer, h_state and the current frame are unaffected.
- h_state changes only on accepted captures and stays stable between them.
- Full throughput: with m_ready held 1, a frame takes exactly H cycles.
- No arithmetic on data: words pass bit-exact, sign preserved.

Optional Feature:
- Macro: GRU_STREAM_PARITY_EN.
- Defined: adds output port m_parity (1 bit), the even parity (XOR-reduce) of m_data, registered alongside m_data. It is valid whenever m_valid=1, held with the data, and resets to 0.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame: reset, then pulse done_in with h_t_in[i]=i*65536 (i.0 in Q10.16), m_ready=1 → m_valid rises the next cycle. m_data sequence 0, 65536, …, 983040 over 16 cycles. m_last only on the 16th word. frame_cnt=1, busy falls, h_state equals the input.
- Backpressure: same frame, m_ready toggled 1,0,0,1 repeating → every element delivered once in order, m_data/m_index stable while stalled, frame_cnt=1.
- Back-to-back: second done_in (h_t_in[i]=-i*65536) in the same cycle as the final handshake → no m_valid gap. Word 17 = 0 and word 18 = 0x3FF0000 (−1.0 in 26-bit two's complement). frame_cnt=2, overrun=0.
- Overrun: done_in at index 5 with different data → frame continues with the original values, overrun=1 and stays 1 after the frame, h_state unchanged.
- Reset mid-frame: assert rst_n=0 at index 8 → m_valid, busy, frame_cnt and h_state are 0 immediately (asynchronous). After release, a new done_in streams from index 0.
- Wrap/parity: FRAME_CNT_W=2, run 5 frames → frame_cnt sequence 1,2,3,0,1. With GRU_STREAM_PARITY_EN defined, m_data=0x0000007 gives m_parity=1 and m_data=0x0000003 gives m_parity=0.
